// File: rtl/adma_as_atx_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adma_as_atx_issue_pkg
// Brief    : Shared ADMA AXI burst / response encodings and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package adma_as_atx_issue_pkg;

   localparam logic [1:0] BURST_FIX   = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adma_as_atx_issue_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, power-of-two depth, wrap-bit full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
   import adma_as_atx_issue_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              empty,
   output logic              full
);

   localparam int c_PTR_W = $clog2(DEPTH);

   logic [c_PTR_W:0]  r_wr_ptr;
   logic [c_PTR_W:0]  r_rd_ptr;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_do_push;
   logic              w_do_pop;

   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   // Extra MSB distinguishes full from empty when the index bits match
   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                  (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
   assign pop_data = r_mem[r_rd_ptr[c_PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/adma_as_atx_issue.sv
`default_nettype none
// ============================================================================
// Module   : adma_as_atx_issue
// Brief    : Issues fetched DMA bursts on AXI AR/AW, tracks B, reports done.
// Revision : 1.0 - initial release
// ============================================================================
module adma_as_atx_issue
   import adma_as_atx_issue_pkg::*;
#(
   parameter int MST_ID_W   = 5,
   parameter int SRC_ADDR_W = 32,
   parameter int DST_ADDR_W = 32,
   parameter int ATX_LEN_W  = 8,
   parameter int MAX_OUTSTD = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [MST_ID_W-1:0]         arid,
   input  logic [SRC_ADDR_W-1:0]       araddr,
   input  logic [ATX_LEN_W-1:0]        arlen,
   input  logic [1:0]                  arburst,
   input  logic [MST_ID_W-1:0]         awid,
   input  logic [DST_ADDR_W-1:0]       awaddr,
   input  logic [ATX_LEN_W-1:0]        awlen,
   input  logic [1:0]                  awburst,
   input  logic                        atx_last,
   input  logic                        atx_vld,
   output logic                        atx_rdy,
   output logic [MST_ID_W-1:0]         m_arid,
   output logic [SRC_ADDR_W-1:0]       m_araddr,
   output logic [ATX_LEN_W-1:0]        m_arlen,
   output logic [1:0]                  m_arburst,
   output logic                        m_arvalid,
   input  logic                        m_arready,
   output logic [MST_ID_W-1:0]         m_awid,
   output logic [DST_ADDR_W-1:0]       m_awaddr,
   output logic [ATX_LEN_W-1:0]        m_awlen,
   output logic [1:0]                  m_awburst,
   output logic                        m_awvalid,
   input  logic                        m_awready,
   input  logic [1:0]                  m_bresp,
   input  logic                        m_bvalid,
   output logic                        m_bready,
   output logic                        tx_done,
   output logic                        tx_err,
   output logic [$clog2(MAX_OUTSTD):0] outstd_cnt
);

   localparam int c_CNT_W  = $clog2(MAX_OUTSTD) + 1;
   localparam int c_AWQ_W  = MST_ID_W + DST_ADDR_W + ATX_LEN_W + 2 + 1;
   localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_OUTSTD);

   logic                  r_ar_vld;
   logic [MST_ID_W-1:0]   r_arid;
   logic [SRC_ADDR_W-1:0] r_araddr;
   logic [ATX_LEN_W-1:0]  r_arlen;
   logic [1:0]            r_arburst;
   logic [c_CNT_W-1:0]    r_outstd_cnt;
   logic                  r_err_acc;
   logic                  r_tx_done;
   logic                  r_tx_err;

   logic                  w_atx_acc;
   logic                  w_aw_empty;
   logic                  w_aw_full;
   logic                  w_aw_pop;
   logic [c_AWQ_W-1:0]    w_aw_head;
   logic                  w_aw_last;
   logic                  w_b_empty;
   logic                  w_b_full;
   logic                  w_b_hs;
   logic                  w_b_tag_last;
   logic                  w_b_err;

   assign atx_rdy   = (~r_ar_vld | m_arready) & ~w_aw_full & (r_outstd_cnt < c_MAX_CNT);
   assign w_atx_acc = atx_vld & atx_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ar_vld  <= 1'b0;
         r_arid    <= '0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arburst <= '0;
      end else if (w_atx_acc) begin
         r_ar_vld  <= 1'b1;
         r_arid    <= arid;
         r_araddr  <= araddr;
         r_arlen   <= arlen;
         r_arburst <= arburst;
      end else if (m_arready) begin
         r_ar_vld  <= 1'b0;
      end
   end

   assign m_arvalid = r_ar_vld;
   assign m_arid    = r_arid;
   assign m_araddr  = r_araddr;
   assign m_arlen   = r_arlen;
   assign m_arburst = r_arburst;

   sync_fifo #(.DATA_W(c_AWQ_W), .DEPTH(MAX_OUTSTD)) u_aw_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_atx_acc),
      .push_data ({awid, awaddr, awlen, awburst, atx_last}),
      .pop       (w_aw_pop),
      .pop_data  (w_aw_head),
      .empty     (w_aw_empty),
      .full      (w_aw_full)
   );

   assign m_awvalid = ~w_aw_empty;
   assign w_aw_pop  = m_awvalid & m_awready;
   assign {m_awid, m_awaddr, m_awlen, m_awburst, w_aw_last} = w_aw_head;

   // Tags enter in AW issue order, matching the order B responses return
   sync_fifo #(.DATA_W(1), .DEPTH(MAX_OUTSTD)) u_b_tag_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_aw_pop & ~w_b_full),
      .push_data (w_aw_last),
      .pop       (w_b_hs),
      .pop_data  (w_b_tag_last),
      .empty     (w_b_empty),
      .full      (w_b_full)
   );

   assign m_bready = ~w_b_empty;
   assign w_b_hs   = m_bvalid & m_bready;
   assign w_b_err  = resp_is_err(m_bresp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outstd_cnt <= '0;
      end else begin
         case ({w_atx_acc, w_b_hs})
            2'b10:   r_outstd_cnt <= r_outstd_cnt + c_CNT_W'(1);
            2'b01:   r_outstd_cnt <= r_outstd_cnt - c_CNT_W'(1);
            default: r_outstd_cnt <= r_outstd_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_acc <= 1'b0;
         r_tx_done <= 1'b0;
         r_tx_err  <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         r_tx_err  <= 1'b0;
         if (w_b_hs) begin
            if (w_b_tag_last) begin
               r_tx_done <= 1'b1;
               r_tx_err  <= r_err_acc | w_b_err;
               r_err_acc <= 1'b0;
            end else if (w_b_err) begin
               r_err_acc <= 1'b1;
            end
         end
      end
   end

   assign tx_done    = r_tx_done;
   assign tx_err     = r_tx_err;
   assign outstd_cnt = r_outstd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adma_as_atx_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_adma_as_atx_issue
// Brief    : Directed self-checking bench for adma_as_atx_issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adma_as_atx_issue;
   import adma_as_atx_issue_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  arid, awid, m_arid, m_awid;
   logic [31:0] araddr, awaddr, m_araddr, m_awaddr;
   logic [7:0]  arlen, awlen, m_arlen, m_awlen;
   logic [1:0]  arburst, awburst, m_arburst, m_awburst, m_bresp;
   logic        atx_last, atx_vld, atx_rdy;
   logic        m_arvalid, m_arready, m_awvalid, m_awready, m_bvalid, m_bready;
   logic        tx_done, tx_err;
   logic [2:0]  outstd_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   adma_as_atx_issue dut (
      .clk(clk), .rst_n(rst_n),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
      .atx_last(atx_last), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .tx_done(tx_done), .tx_err(tx_err), .outstd_cnt(outstd_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_atx(input logic [31:0] ra, input logic [31:0] wa,
                            input logic [7:0] len, input logic last);
      atx_vld  = 1'b1;
      arid     = 5'd1;
      awid     = 5'd2;
      araddr   = ra;
      awaddr   = wa;
      arlen    = len;
      awlen    = len;
      arburst  = BURST_INCR;
      awburst  = BURST_INCR;
      atx_last = last;
   endtask

   // Holds m_bvalid until every outstanding burst is answered; returns tx_done pulses seen
   task automatic drain(output int dones);
      dones = 0;
      m_bvalid = 1'b1;
      m_bresp  = RESP_OKAY;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (tx_done) dones++;
         if (outstd_cnt == 3'd0) break;
      end
      m_bvalid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      atx_vld = 1'b0; atx_last = 1'b0;
      arid = '0; awid = '0; araddr = '0; awaddr = '0;
      arlen = '0; awlen = '0; arburst = '0; awburst = '0;
      m_arready = 1'b1; m_awready = 1'b1; m_bvalid = 1'b0; m_bresp = RESP_OKAY;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: observed %0h expected 0", m_arvalid); end
      n_cmp++; if (m_awvalid !== 1'b0) begin n_err++; $display("FAIL rst_awvalid: observed %0h expected 0", m_awvalid); end
      n_cmp++; if (m_bready !== 1'b0) begin n_err++; $display("FAIL rst_bready: observed %0h expected 0", m_bready); end
      n_cmp++; if (outstd_cnt !== 3'd0) begin n_err++; $display("FAIL rst_cnt: observed %0h expected 0", outstd_cnt); end
      n_cmp++; if ({tx_done, tx_err} !== 2'b00) begin n_err++; $display("FAIL rst_done_err: observed %0h expected 0", {tx_done, tx_err}); end
      rst_n = 1'b1;
      tick;
      n_cmp++; if (atx_rdy !== 1'b1) begin n_err++; $display("FAIL rst_atx_rdy: observed %0h expected 1", atx_rdy); end
   endtask

   task automatic test_single;
      drive_atx(32'h1000, 32'h2000, 8'd3, 1'b1);
      #1;
      n_cmp++; if (atx_rdy !== 1'b1) begin n_err++; $display("FAIL single_rdy: observed %0h expected 1", atx_rdy); end
      tick;
      atx_vld = 1'b0;
      n_cmp++; if ({m_arvalid, m_araddr, m_arlen} !== {1'b1, 32'h1000, 8'd3}) begin n_err++; $display("FAIL single_ar: observed %0h expected %0h", {m_arvalid, m_araddr, m_arlen}, {1'b1, 32'h1000, 8'd3}); end
      n_cmp++; if ({m_awvalid, m_awaddr, m_awlen, m_awid} !== {1'b1, 32'h2000, 8'd3, 5'd2}) begin n_err++; $display("FAIL single_aw: observed %0h expected %0h", {m_awvalid, m_awaddr, m_awlen, m_awid}, {1'b1, 32'h2000, 8'd3, 5'd2}); end
      n_cmp++; if (outstd_cnt !== 3'd1) begin n_err++; $display("FAIL single_cnt: observed %0h expected 1", outstd_cnt); end
      tick;
      n_cmp++; if ({m_arvalid, m_awvalid, m_bready} !== 3'b001) begin n_err++; $display("FAIL single_issued: observed %0h expected 1", {m_arvalid, m_awvalid, m_bready}); end
      m_bvalid = 1'b1; m_bresp = RESP_OKAY;
      tick;
      m_bvalid = 1'b0;
      n_cmp++; if ({tx_done, tx_err} !== 2'b10) begin n_err++; $display("FAIL single_done: observed %0h expected 2", {tx_done, tx_err}); end
      n_cmp++; if ({outstd_cnt, m_bready} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL single_idle: observed %0h expected 0", {outstd_cnt, m_bready}); end
      tick;
      n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL single_pulse: observed %0h expected 0", tx_done); end
   endtask

   task automatic test_outstanding;
      int acc;
      int dones;
      acc = 0;
      drive_atx(32'h100, 32'h200, 8'd0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         #1;
         if (atx_rdy) acc++;
         tick;
      end
      n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL outstd_accepts: observed %0d expected 4", acc); end
      n_cmp++; if ({outstd_cnt, atx_rdy} !== {3'd4, 1'b0}) begin n_err++; $display("FAIL outstd_full: observed %0h expected 8", {outstd_cnt, atx_rdy}); end
      m_bvalid = 1'b1; m_bresp = RESP_OKAY;
      tick;
      m_bvalid = 1'b0;
      drive_atx(32'h500, 32'h600, 8'd1, 1'b1);
      #1;
      n_cmp++; if ({outstd_cnt, atx_rdy} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL outstd_reopen: observed %0h expected 7", {outstd_cnt, atx_rdy}); end
      tick;
      atx_vld = 1'b0;
      n_cmp++; if (outstd_cnt !== 3'd4) begin n_err++; $display("FAIL outstd_fifth: observed %0h expected 4", outstd_cnt); end
      drain(dones);
      n_cmp++; if ({dones, outstd_cnt} !== {32'd1, 3'd0}) begin n_err++; $display("FAIL outstd_drain: observed %0h expected %0h", {dones, outstd_cnt}, {32'd1, 3'd0}); end
   endtask

   task automatic test_ar_stall;
      int bad;
      bad = 0;
      m_arready = 1'b0;
      drive_atx(32'h3000, 32'h3800, 8'd7, 1'b1);
      tick;
      drive_atx(32'h4000, 32'h4800, 8'd2, 1'b1);
      #1;
      n_cmp++; if (atx_rdy !== 1'b0) begin n_err++; $display("FAIL stall_rdy: observed %0h expected 0", atx_rdy); end
      for (int i = 0; i < 10; i++) begin
         tick;
         n_cmp++; if ({m_arvalid, m_araddr, m_arlen, atx_rdy} !== {1'b1, 32'h3000, 8'd7, 1'b0}) begin n_err++; $display("FAIL stall_hold: observed %0h expected %0h", {m_arvalid, m_araddr, m_arlen, atx_rdy}, {1'b1, 32'h3000, 8'd7, 1'b0}); end
      end
      atx_vld = 1'b0;
      m_arready = 1'b1;
      tick;
      n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL stall_release: observed %0h expected 0", m_arvalid); end
      m_bvalid = 1'b1; m_bresp = RESP_OKAY;
      tick;
      m_bvalid = 1'b0;
      n_cmp++; if ({tx_done, tx_err, outstd_cnt} !== {2'b10, 3'd0}) begin n_err++; $display("FAIL stall_done: observed %0h expected 10", {tx_done, tx_err, outstd_cnt}); end
   endtask

   task automatic test_multi_burst;
      logic [1:0] resp_seq [3];
      logic [1:0] exp_seq  [3];
      resp_seq[0] = RESP_OKAY; resp_seq[1] = RESP_SLVERR; resp_seq[2] = RESP_OKAY;
      exp_seq[0]  = 2'b00;     exp_seq[1]  = 2'b00;       exp_seq[2]  = 2'b11;
      drive_atx(32'h10, 32'h20, 8'd1, 1'b0); tick;
      drive_atx(32'h30, 32'h40, 8'd1, 1'b0); tick;
      drive_atx(32'h50, 32'h60, 8'd1, 1'b1); tick;
      atx_vld = 1'b0;
      m_bvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         m_bresp = resp_seq[i];
         tick;
         n_cmp++; if ({tx_done, tx_err} !== exp_seq[i]) begin n_err++; $display("FAIL multi_b%0d: observed %0h expected %0h", i, {tx_done, tx_err}, exp_seq[i]); end
      end
      m_bvalid = 1'b0;
      tick;
      n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL multi_pulse: observed %0h expected 0", tx_done); end
      drive_atx(32'h70, 32'h80, 8'd0, 1'b1); tick;
      atx_vld = 1'b0; tick;
      m_bvalid = 1'b1; m_bresp = RESP_OKAY; tick;
      m_bvalid = 1'b0;
      n_cmp++; if ({tx_done, tx_err} !== 2'b10) begin n_err++; $display("FAIL multi_clean: observed %0h expected 2", {tx_done, tx_err}); end
      drive_atx(32'h90, 32'hA0, 8'd0, 1'b1); tick;
      atx_vld = 1'b0; tick;
      m_bvalid = 1'b1; m_bresp = RESP_DECERR; tick;
      m_bvalid = 1'b0;
      n_cmp++; if ({tx_done, tx_err} !== 2'b11) begin n_err++; $display("FAIL multi_last_err: observed %0h expected 3", {tx_done, tx_err}); end
   endtask

   task automatic test_back_to_back;
      int dones;
      drive_atx(32'hB0, 32'hC0, 8'd0, 1'b0); tick;
      drive_atx(32'hD0, 32'hE0, 8'd0, 1'b0); tick;
      atx_vld = 1'b0; tick;
      n_cmp++; if ({outstd_cnt, m_bready} !== {3'd2, 1'b1}) begin n_err++; $display("FAIL b2b_pre: observed %0h expected 5", {outstd_cnt, m_bready}); end
      drive_atx(32'hF0, 32'hF8, 8'd0, 1'b1);
      m_bvalid = 1'b1; m_bresp = RESP_OKAY;
      #1;
      n_cmp++; if (atx_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy: observed %0h expected 1", atx_rdy); end
      tick;
      atx_vld = 1'b0;
      n_cmp++; if (outstd_cnt !== 3'd2) begin n_err++; $display("FAIL b2b_cnt: observed %0h expected 2", outstd_cnt); end
      drain(dones);
      n_cmp++; if ({dones, outstd_cnt} !== {32'd1, 3'd0}) begin n_err++; $display("FAIL b2b_drain: observed %0h expected %0h", {dones, outstd_cnt}, {32'd1, 3'd0}); end
   endtask

   task automatic test_reset_mid;
      m_awready = 1'b0;
      drive_atx(32'h1100, 32'h2100, 8'd0, 1'b0); tick;
      drive_atx(32'h1200, 32'h2200, 8'd0, 1'b0); tick;
      drive_atx(32'h1300, 32'h2300, 8'd0, 1'b1); tick;
      atx_vld = 1'b0;
      m_arready = 1'b0;
      #1;
      n_cmp++; if ({outstd_cnt, m_arvalid, m_awvalid} !== {3'd3, 2'b11}) begin n_err++; $display("FAIL rmid_pre: observed %0h expected f", {outstd_cnt, m_arvalid, m_awvalid}); end
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({m_arvalid, m_awvalid, m_bready, outstd_cnt} !== 6'd0) begin n_err++; $display("FAIL rmid_async: observed %0h expected 0", {m_arvalid, m_awvalid, m_bready, outstd_cnt}); end
      tick;
      rst_n = 1'b1;
      m_arready = 1'b1; m_awready = 1'b1;
      m_bvalid = 1'b1; m_bresp = RESP_OKAY;
      for (int i = 0; i < 10; i++) begin
         tick;
         n_cmp++; if ({m_arvalid, m_awvalid, m_bready, tx_done} !== 4'd0) begin n_err++; $display("FAIL rmid_quiet: observed %0h expected 0", {m_arvalid, m_awvalid, m_bready, tx_done}); end
      end
      m_bvalid = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single;
      test_outstanding;
      test_ar_stall;
      test_multi_burst;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/adma_as_atx_issue.md
ADMA_AS_ATX_ISSUE -- requirements
Module: adma_as_atx_issue

Interface
REQ-001 Parameter MST_ID_W, default 5, AXI ID width.
REQ-002 Parameter SRC_ADDR_W / DST_ADDR_W, default 32 / 32, AR / AW address width.
REQ-003 Parameter ATX_LEN_W, default 8, AxLEN width (encoded, beats = len+1).
REQ-004 Parameter MAX_OUTSTD, default 4, power of two, max accepted-but-unresponded transactions; sets AW queue and B-tag queue depth.
REQ-005 Ports: clk  in  1  single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 arid/araddr/arlen/arburst  in  MST_ID_W/SRC_ADDR_W/ATX_LEN_W/2  read-side transaction info from fetch stage.
REQ-007 awid/awaddr/awlen/awburst  in  MST_ID_W/DST_ADDR_W/ATX_LEN_W/2  write-side transaction info from fetch stage.
REQ-008 atx_last  in  1  transaction is final burst of its DMA transfer; atx_vld  in  1; atx_rdy  out  1.
REQ-009 m_arid/m_araddr/m_arlen/m_arburst  out  field widths; m_arvalid  out  1; m_arready  in  1.
REQ-010 m_awid/m_awaddr/m_awlen/m_awburst  out  field widths; m_awvalid  out  1; m_awready  in  1.
REQ-011 m_bresp  in  2; m_bvalid  in  1; m_bready  out  1.
REQ-012 tx_done  out  1  one-cycle pulse, DMA transfer finished; tx_err  out  1  valid with tx_done, any burst of transfer returned non-OKAY.
REQ-013 outstd_cnt  out  $clog2(MAX_OUTSTD)+1  current outstanding count.

Function
REQ-014 atx_rdy SHALL be combinational: 1 iff (AR slot empty or m_arready) and AW queue not full and outstd_cnt < MAX_OUTSTD.
REQ-015 On atx_vld&atx_rdy, AR fields SHALL load the AR slot (m_arvalid=1 next cycle) and {aw fields, atx_last} SHALL push the AW queue same edge.
REQ-016 AR slot SHALL hold fields stable while m_arvalid&~m_arready; clears on handshake unless reloaded same edge.
REQ-017 AW channel SHALL present AW queue head; m_awvalid = queue not empty; pop on m_awvalid&m_awready; AW may issue before, with, or after its AR.
REQ-018 On AW pop, atx_last SHALL push the B-tag queue (depth MAX_OUTSTD, never overflows per REQ-014).
REQ-019 m_bready SHALL equal B-tag queue not empty; each B handshake pops one tag.
REQ-020 outstd_cnt SHALL +1 on atx accept, -1 on B handshake, unchanged when both same cycle.
REQ-021 Error accumulator SHALL set on B handshake with m_bresp != 2'b00; tx_err = accumulator OR current bresp error.
REQ-022 tx_done SHALL pulse the cycle after a B handshake popping tag last=1 (registered); tx_err registered alongside; accumulator clears that edge.
REQ-023 B handshake arriving with B-tag queue empty SHALL NOT occur (m_bready=0); stray m_bvalid ignored.
REQ-024 Queue pointers SHALL wrap modulo depth with extra wrap bit for full/empty; push+pop on full AW queue not permitted (atx_rdy=0).
REQ-025 Throughput SHALL be one transaction per cycle when both channels ready and outstd_cnt < MAX_OUTSTD.

Reset
REQ-026 rst_n low SHALL asynchronously clear: AR slot valid, both queues empty, outstd_cnt=0, accumulator=0, tx_done=0, tx_err=0; m_arvalid=m_awvalid=m_bready=0.
REQ-027 Reset mid-operation SHALL drop all in-flight state without issuing further AR/AW; no tx_done follows.

Structure
REQ-028 BURST_FIX/BURST_INCR and RESP_OKAY/SLVERR/DECERR constants SHALL live in the shared adma package.
REQ-029 One sub-module, sync_fifo (parameters DATA_W, DEPTH), SHALL be instantiated twice: AW queue and B-tag queue.

Verification
REQ-030 Single atx araddr=0x1000, awaddr=0x2000, len=3, last=1, channels always ready, bresp=OKAY -> one AR, one AW len=3, tx_done=1 tx_err=0 one cycle after B.
REQ-031 5 back-to-back atx, bvalid held low, MAX_OUTSTD=4 -> 4 accepted, atx_rdy=0 with outstd_cnt=4; one B -> fifth accepted next cycle.
REQ-032 m_arready held low 10 cycles -> m_ar* stable, m_arvalid=1 throughout, atx_rdy=0 after slot full.
REQ-033 3-burst transfer (last=0,0,1), second bresp=SLVERR -> no tx_done for first two, final tx_done=1 with tx_err=1; next transfer all OKAY -> tx_err=0.
REQ-034 B handshake coinciding with new atx accept at outstd_cnt=2 -> outstd_cnt stays 2.
REQ-035 rst_n asserted with 3 outstanding -> all valids 0 immediately, outstd_cnt=0, no tx_done after release.
